// File: rtl/i2c_inject_tx.sv
// i2c_inject_tx: write-only I2C master (START, addr+W, streamed data bytes, STOP) reporting {byte, ack} frames.
// Define I2C_STRETCH_EN to honour responder clock stretching in the SCL-high phase.
module i2c_inject_tx #(
  parameter int CLK_DIV = 250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_req,
  input  logic [6:0] dev_addr,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       scl_oe,
  output logic       sda_oe,
  output logic [8:0] frame_out,
  output logic       frame_valid,
  output logic       busy,
  output logic       done,
  output logic       nack
);
  localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
  typedef enum logic [2:0] {IDLE, START, ADDR, DATA, ACK, WAIT, STOP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [1:0] q;
  logic [2:0] bit_cnt;
  logic [7:0] byte_r;
  logic last, ack_r, stall, adv, tick, end_cell, sda_c;
  assign adv = cnt == CNT_MAX;
`ifdef I2C_STRETCH_EN
  // A stretched cell parks at the end of q2; q3 then starts only once SCL is really high.
  assign stall = q == 2'd2 && !scl_in && (state == ADDR || state == DATA || state == ACK);
`else
  logic unused_scl;
  assign unused_scl = scl_in;
  assign stall = 1'b0;
`endif
  assign tick = adv && !stall;
  assign end_cell = tick && q == 2'd3;
  assign tx_ready = state == WAIT;
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    scl_oe = 1'b0;
    sda_c = 1'b0;
    unique case (state)
      IDLE: state_n = start_req ? START : IDLE;
      START: begin
        sda_c = q[1];
        state_n = end_cell ? ADDR : START;
      end
      ADDR, DATA: begin
        scl_oe = !q[1];
        sda_c = !byte_r[bit_cnt];
        if (end_cell && bit_cnt == 3'd0) state_n = ACK;
      end
      ACK: begin
        scl_oe = !q[1];
        if (end_cell) state_n = (ack_r || last) ? STOP : WAIT;
      end
      WAIT: begin
        scl_oe = 1'b1;
        if (tx_valid) state_n = DATA;
      end
      STOP: begin
        scl_oe = !q[1];
        sda_c = q != 2'd3;
        if (end_cell) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  // SDA is registered so it always moves one cycle after SCL has been pulled low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      q <= 2'd0;
      bit_cnt <= 3'd0;
      byte_r <= 8'd0;
      last <= 1'b0;
      ack_r <= 1'b0;
      sda_oe <= 1'b0;
      frame_out <= 9'd0;
      frame_valid <= 1'b0;
      done <= 1'b0;
      nack <= 1'b0;
    end else begin
      sda_oe <= sda_c;
      frame_valid <= 1'b0;
      done <= 1'b0;
      if (state == IDLE || state == WAIT) begin
        cnt <= '0;
        q <= 2'd0;
      end else begin
        cnt <= adv ? (stall ? cnt : '0) : cnt + 1'b1;
        if (tick) q <= q + 2'd1;
      end
      if (state == IDLE && start_req) begin
        byte_r <= {dev_addr, 1'b0};
        last <= 1'b0;
        nack <= 1'b0;
        bit_cnt <= 3'd7;
      end
      if (state == WAIT && tx_valid) begin
        byte_r <= tx_data;
        last <= tx_last;
        bit_cnt <= 3'd7;
      end
      if (end_cell && (state == ADDR || state == DATA)) bit_cnt <= bit_cnt - 3'd1;
      if (tick && q == 2'd2 && state == ACK) ack_r <= sda_in;
      if (end_cell && state == ACK) begin
        frame_out <= {byte_r, ack_r};
        frame_valid <= 1'b1;
        if (ack_r) nack <= 1'b1;
      end
      if (end_cell && state == STOP) done <= 1'b1;
    end
  end
endmodule

// File: tb/tb_i2c_inject_tx.sv
// tb_i2c_inject_tx: table-driven transactions against an open-drain bus model with an ACK/NACK responder,
// plus hand sequences for start latency, clock stretching and reset mid-transfer.
module tb_i2c_inject_tx;
  localparam int CD = 8;
  localparam int BOUND = 20000;
  typedef struct {
    logic [6:0] addr;
    int n;
    logic [2:0][7:0] d;
    int nack_at;
    int dly;
    int nf;
    logic [3:0][8:0] f;
    logic exp_nack;
    int exp_rises;
    logic exp_rdy;
  } vec_t;
  logic clk = 0, reset = 0, start_req = 0, tx_last = 0, tx_valid = 0, hold = 0, ack_pull = 0;
  logic [6:0] dev_addr = 0;
  logic [7:0] tx_data = 0;
  logic scl_in, sda_in, tx_ready, scl_oe, sda_oe, frame_valid, busy, done, nack;
  logic [8:0] frame_out;
  int errors = 0, checks = 0, rises = 0, dones = 0, stall_bad = 0, nbits = 0, nack_at = -1;
  logic rdy_seen = 0, scl_prev = 0;
  logic [8:0] rx_sh = 0;
  logic [8:0] frames[$];
  logic [8:0] rx[$];
  vec_t tv[4];
  always #5 clk = ~clk;
  assign scl_in = ~scl_oe & ~hold;
  assign sda_in = ~sda_oe & ~ack_pull;
  i2c_inject_tx #(.CLK_DIV(CD)) dut (
    .clk(clk), .reset(reset), .start_req(start_req), .dev_addr(dev_addr), .tx_data(tx_data),
    .tx_last(tx_last), .tx_valid(tx_valid), .tx_ready(tx_ready), .scl_in(scl_in), .sda_in(sda_in),
    .scl_oe(scl_oe), .sda_oe(sda_oe), .frame_out(frame_out), .frame_valid(frame_valid),
    .busy(busy), .done(done), .nack(nack)
  );
  always @(negedge clk) begin
    if (scl_oe === 1'b1 && scl_prev === 1'b0) rises++;
    scl_prev = scl_oe;
    if (frame_valid === 1'b1) frames.push_back(frame_out);
    if (done === 1'b1) dones++;
    if (tx_ready === 1'b1) rdy_seen = 1'b1;
  end
  // Responder: START resets the bit count, ninth bit of each byte is the ACK slot.
  always @(negedge sda_in) if (scl_in === 1'b1) nbits = 0;
  always @(posedge scl_in) begin
    rx_sh = {rx_sh[7:0], sda_in};
    nbits++;
    if (nbits % 9 == 0) rx.push_back(rx_sh);
  end
  always @(negedge scl_in) ack_pull = (nbits % 9 == 8) && (nbits / 9 != nack_at);
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask
  function automatic vec_t mk(logic [6:0] a, int n, logic [23:0] d, int na, int dly, int nf,
                              logic [35:0] f, logic en, int r, logic rd);
    vec_t v;
    v.addr = a; v.n = n; v.d = d; v.nack_at = na; v.dly = dly;
    v.nf = nf; v.f = f; v.exp_nack = en; v.exp_rises = r; v.exp_rdy = rd;
    return v;
  endfunction
  task automatic run_txn(input vec_t v, input string nm, input bit check);
    int t;
    nack_at = v.nack_at; rises = 0; dones = 0; stall_bad = 0; rdy_seen = 0; nbits = 0;
    frames.delete(); rx.delete();
    @(negedge clk); dev_addr = v.addr; start_req = 1;
    @(negedge clk); start_req = 0;
    for (int i = 0; i < v.n; i++) begin
      t = 0;
      while (!tx_ready && busy && t < BOUND) begin @(negedge clk); t++; end
      if (!tx_ready) break;
      repeat (v.dly) begin
        @(negedge clk);
        if (!scl_oe) stall_bad++;
        start_req = 1; dev_addr = 7'h7F;
      end
      start_req = 0; tx_data = v.d[i]; tx_last = (i == v.n - 1); tx_valid = 1;
      @(negedge clk); tx_valid = 0; tx_last = 0;
    end
    t = 0;
    while (busy && t < BOUND) begin @(negedge clk); t++; end
    chk({nm, " completes"}, t < BOUND, 1);
    @(negedge clk); #1;
    chk({nm, " busy_after"}, busy, 0);
    if (check) begin
      chk({nm, " frame_count"}, frames.size(), v.nf);
      for (int k = 0; k < v.nf; k++) begin
        chk($sformatf("%s frame%0d", nm, k), k < frames.size() ? frames[k] : 9'h1FF, v.f[k]);
        chk($sformatf("%s sda_byte%0d", nm, k), k < rx.size() ? rx[k] : 9'h1FF, v.f[k]);
      end
      chk({nm, " nack"}, nack, v.exp_nack);
      chk({nm, " done_pulses"}, dones, 1);
      chk({nm, " scl_falls"}, rises, v.exp_rises);
      chk({nm, " tx_ready_seen"}, rdy_seen, v.exp_rdy);
      chk({nm, " stall_scl_low"}, stall_bad, 0);
    end
  endtask
  task automatic stretch_probe();
    int t, hi;
    t = 0;
    while (rises < 4 && t < BOUND) begin @(negedge clk); #1; t++; end
    hold = 1;
    t = 0;
    while (scl_oe && t < BOUND) begin @(negedge clk); t++; end
    chk("stretch reach_bit3", t < BOUND, 1);
`ifdef I2C_STRETCH_EN
    repeat (300) @(negedge clk);
    chk("stretch held_in_q2", scl_oe, 0);
    hold = 0;
    for (hi = 0; hi < 1000; hi++) begin @(negedge clk); if (scl_oe) break; end
    chk("stretch high_time", hi, CD);
`else
    for (hi = 1; hi < 1000; hi++) begin @(negedge clk); if (scl_oe) break; end
    chk("no_stretch high_time", hi, 2 * CD);
    hold = 0;
`endif
  endtask
  initial begin
    int k, t;
    tv[0] = mk(7'h4A, 1, {8'h00, 8'h00, 8'h12}, -1, 0, 2, {9'h000, 9'h000, 9'h024, 9'h128}, 0, 19, 1);
    tv[1] = mk(7'h4A, 1, {8'h00, 8'h00, 8'h12}, 0, 0, 1, {9'h000, 9'h000, 9'h000, 9'h129}, 1, 10, 0);
    tv[2] = mk(7'h3C, 3, {8'hFF, 8'h00, 8'hA5}, -1, 50, 4, {9'h1FE, 9'h000, 9'h14A, 9'h0F0}, 0, 37, 1);
    tv[3] = mk(7'h20, 2, {8'h00, 8'h66, 8'h55}, 1, 3, 2, {9'h000, 9'h000, 9'h0AB, 9'h080}, 1, 19, 1);
    repeat (3) @(negedge clk);
    chk("reset scl_oe", scl_oe, 0);
    chk("reset sda_oe", sda_oe, 0);
    chk("reset tx_ready", tx_ready, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset frame_valid", frame_valid, 0);
    chk("reset nack", nack, 0);
    @(negedge clk); reset = 1;
    repeat (2) @(negedge clk);
    nack_at = 0; nbits = 0;
    @(negedge clk); dev_addr = 7'h4A; start_req = 1;
    @(posedge clk); #1; start_req = 0;
    chk("busy after accept", busy, 1);
    k = 0;
    while (!sda_oe && k < 1000) begin @(posedge clk); #1; k++; end
    chk("start latency", k, 2 * CD + 1);
    t = 0;
    while (busy && t < BOUND) begin @(negedge clk); t++; end
    @(negedge clk); #1;
    chk("latency txn nack", nack, 1);
    for (int i = 0; i < 4; i++) run_txn(tv[i], $sformatf("vec%0d", i), 1);
`ifdef I2C_STRETCH_EN
    fork
      run_txn(tv[0], "stretch", 1);
      stretch_probe();
    join
`else
    fork
      run_txn(tv[0], "stretch", 0);
      stretch_probe();
    join
`endif
    nack_at = -1; rises = 0; nbits = 0;
    @(negedge clk); dev_addr = 7'h4A; start_req = 1;
    @(negedge clk); start_req = 0;
    t = 0;
    while (!tx_ready && t < BOUND) begin @(negedge clk); t++; end
    tx_data = 8'h12; tx_last = 1; tx_valid = 1;
    @(negedge clk); tx_valid = 0; tx_last = 0;
    t = 0;
    while (rises < 12 && t < BOUND) begin @(negedge clk); #1; t++; end
    chk("mid_data scl_low", scl_oe, 1);
    dones = 0;
    reset = 0; #1;
    chk("async reset scl_oe", scl_oe, 0);
    chk("async reset sda_oe", sda_oe, 0);
    chk("async reset busy", busy, 0);
    @(negedge clk); reset = 1;
    repeat (4 * CD) @(negedge clk);
    #1;
    chk("no stop after reset", dones, 0);
    run_txn(tv[0], "after_reset", 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #10000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
